// File: rtl/bpu_resolve_ctrl.sv
// Branch prediction resolve controller: queues fetch-time predictions,
// checks them at MEM resolution, drives predictor update and flush.
//
// Ports:
//   clk, reset           clock (rising), async active-high reset
//   if_valid/if_pc/      fetched instruction and its predicted next PC;
//   if_pred_pc/if_stall  pushed unless IF is stalled or the queue is full
//   res_valid/res_pc/    MEM resolves the oldest in-flight instruction
//   res_next_pc
//   q_full               combinational, IF must stall
//   bpu_w_en/bpu_tag_pc/ one-cycle predictor update on a mispredict
//   bpu_next_pc
//   flush                squash IF/ID/EX for FLUSH_CYCLES cycles
//   redirect_valid/_pc   one-cycle fetch redirect
//   sync_err             sticky ordering/overflow/underflow flag
//
// Optional: define BPU_PERF_CNT_EN to add the saturating counters
// perf_resolved, perf_mispred and perf_flush_cyc (32 bits each).

module bpu_resolve_ctrl #(
    parameter int DEPTH        = 4,
    parameter int PC_WIDTH     = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_valid,
    input  logic [PC_WIDTH-1:0] if_pc,
    input  logic [PC_WIDTH-1:0] if_pred_pc,
    input  logic                if_stall,
    input  logic                res_valid,
    input  logic [PC_WIDTH-1:0] res_pc,
    input  logic [PC_WIDTH-1:0] res_next_pc,
    output logic                q_full,
    output logic                bpu_w_en,
    output logic [PC_WIDTH-1:0] bpu_tag_pc,
    output logic [PC_WIDTH-1:0] bpu_next_pc,
    output logic                flush,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                sync_err
`ifdef BPU_PERF_CNT_EN
    ,
    output logic [31:0]         perf_resolved,
    output logic [31:0]         perf_mispred,
    output logic [31:0]         perf_flush_cyc
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] FL_LOAD  = CW'(FLUSH_CYCLES - 1);

    typedef enum logic {
        S_RUN,
        S_FLUSH
    } state_e;

    // Prediction queue storage
    logic [PC_WIDTH-1:0] pc_mem_q   [DEPTH];
    logic [PC_WIDTH-1:0] pred_mem_q [DEPTH];

    state_e              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [CW-1:0]       fcnt_q, fcnt_d;
    logic                w_en_q, w_en_d;
    logic [PC_WIDTH-1:0] tag_q, tag_d;
    logic [PC_WIDTH-1:0] nxt_q, nxt_d;
    logic                rv_q, rv_d;
    logic [PC_WIDTH-1:0] rpc_q, rpc_d;
    logic                flush_q, flush_d;
    logic                serr_q, serr_d;

    logic                run;
    logic                full;
    logic                empty;
    logic                push_req;
    logic                push;
    logic                pop;
    logic                drop;
    logic                pop_empty;
    logic                order_err;
    logic                mispred;
    logic [PC_WIDTH-1:0] head_pc;
    logic [PC_WIDTH-1:0] head_pred;

    assign run   = (state_q == S_RUN);
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    assign head_pc   = pc_mem_q[rd_ptr_q];
    assign head_pred = pred_mem_q[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a full queue still accepts
    // the push; only an unmatched push into a full queue is dropped.
    assign push_req  = if_valid && !if_stall && run;
    assign pop       = res_valid && !empty && run;
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign pop_empty = res_valid && empty && run;
    assign order_err = pop && (head_pc != res_pc);
    assign mispred   = pop && (res_next_pc != head_pred);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fcnt_d   = fcnt_q;
        w_en_d   = 1'b0;
        tag_d    = tag_q;
        nxt_d    = nxt_q;
        rv_d     = 1'b0;
        rpc_d    = rpc_q;
        flush_d  = flush_q;
        serr_d   = serr_q | drop | pop_empty | order_err;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

        unique case (state_q)
            S_RUN: begin
                if (mispred) begin
                    state_d  = S_FLUSH;
                    fcnt_d   = FL_LOAD;
                    flush_d  = 1'b1;
                    w_en_d   = 1'b1;
                    tag_d    = res_pc;
                    nxt_d    = res_next_pc;
                    rv_d     = 1'b1;
                    rpc_d    = res_next_pc;
                    // Everything younger is wrong-path: drop it all.
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end
            end
            S_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = S_RUN;
                    flush_d = 1'b0;
                end else begin
                    fcnt_d = fcnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= if_pc;
            pred_mem_q[wr_ptr_q] <= if_pred_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fcnt_q   <= '0;
            w_en_q   <= 1'b0;
            tag_q    <= '0;
            nxt_q    <= '0;
            rv_q     <= 1'b0;
            rpc_q    <= '0;
            flush_q  <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fcnt_q   <= fcnt_d;
            w_en_q   <= w_en_d;
            tag_q    <= tag_d;
            nxt_q    <= nxt_d;
            rv_q     <= rv_d;
            rpc_q    <= rpc_d;
            flush_q  <= flush_d;
            serr_q   <= serr_d;
        end
    end

    assign q_full         = full;
    assign bpu_w_en       = w_en_q;
    assign bpu_tag_pc     = tag_q;
    assign bpu_next_pc    = nxt_q;
    assign flush          = flush_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign sync_err       = serr_q;

`ifdef BPU_PERF_CNT_EN
    logic [31:0] pres_q, pres_d;
    logic [31:0] pmis_q, pmis_d;
    logic [31:0] pfl_q, pfl_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        pres_d = pres_q;
        pmis_d = pmis_q;
        pfl_d  = pfl_q;
        if (pop && (pres_q != '1)) begin
            pres_d = pres_q + 32'd1;
        end
        if (mispred && (pmis_q != '1)) begin
            pmis_d = pmis_q + 32'd1;
        end
        if (flush_q && (pfl_q != '1)) begin
            pfl_d = pfl_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pres_q <= '0;
            pmis_q <= '0;
            pfl_q  <= '0;
        end else begin
            pres_q <= pres_d;
            pmis_q <= pmis_d;
            pfl_q  <= pfl_d;
        end
    end

    assign perf_resolved  = pres_q;
    assign perf_mispred   = pmis_q;
    assign perf_flush_cyc = pfl_q;
`endif

endmodule
